tc1_emulator: RTL and testbench
===============================

Name: tc1_emulator

Overview:
- SPI responder that models the MAX31855 side of the Pmod TC1 link.
- Returns a 32-bit thermocouple frame to an SPI master, such as our tc1 interface, whenever CS is low.
- Used in the bench and on-board loopback to check master reads without a physical Pmod.
- SCLK/CS are oversampled in the system clock domain; all logic is single-clock.

Parameters:
- SYNC_STAGES, 2, synchronizer flops on SCLK and CS (minimum 2).
- IDLE_MISO, 1'b0, MISO level while CS is high or after bit 31.

Ports:
- clk  input  1  system clock; must be at least 10x SCLK frequency.
- rst  input  1  synchronous, active-low reset.
- SCLK  input  1  SPI clock from master, asynchronous to clk.
- CS  input  1  chip select from master, active low, asynchronous to clk.
- MISO  output  1  serial data to master.
- temp_termoc_in  input  14  thermocouple temperature, two's complement.
- temp_internal_in  input  12  internal temperature, two's complement.
- status_in  input  3  {SCV, SCG, OC}.
- load  input  1  one-cycle strobe: capture inputs into the shadow frame.
- busy  output  1  high while a transaction is active (synchronized CS low).
- frame_done  output  1  one-cycle pulse when 32 bits have been shifted and CS rises.
- frame_abort  output  1  one-cycle pulse when CS rises before 32 falling SCLK edges.
- bit_count  output  6  falling SCLK edges seen in the current transaction (0..32, saturates).

Behaviour:
- Reset (rst=0 at posedge clk) forces:
  - MISO=IDLE_MISO, busy=0, frame_done=0, frame_abort=0, bit_count=0.
  - Shadow frame = 0, pending load cleared.
  - State = IDLE.
  - Sync flops preset to SCLK=0, CS=1.
- Synchronization: SCLK and CS each pass SYNC_STAGES flops plus one edge-detect flop. Edges are derived only from synchronized values.
- Frame format, MSB first:
  - [31:18] temp_termoc.
  - [17] 0.
  - [16] fault = |status.
  - [15:4] temp_internal.
  - [3] 0.
  - [2:0] status.
- Shadow register:
  - load in IDLE → capture inputs on the next clk edge.
  - load while busy → set the pending flag with the inputs captured at that cycle; apply on the first cycle back in IDLE.
  - Repeated loads while busy: the last one wins.
- State machine, states IDLE, SHIFT, TAIL:
  - IDLE → SHIFT on synchronized CS falling edge. Same cycle: shift register ← shadow frame, bit_count ← 0, MISO ← frame[31].
  - SHIFT:
    - On each synchronized SCLK falling edge: bit_count+1, shift left, MISO ← next bit.
    - SCLK rising edges change nothing; the master samples on rising.
    - After the 32nd falling edge → TAIL, MISO=IDLE_MISO.
  - TAIL: extra SCLK edges are ignored; bit_count holds at 32.
  - Exit on any CS rising edge → IDLE, with MISO=IDLE_MISO and busy=0 the next cycle.
    - If bit_count==32 → frame_done pulse, otherwise → frame_abort pulse.
    - Short reads are legal: the master may stop after 14 or 16 bits; that counts as an abort but is not an error.
- Latency: MISO updates SYNC_STAGES+1 clk cycles after a raw SCLK falling edge or raw CS falling edge. At 10x SCLK oversampling this is below half an SCLK period.
- busy mirrors synchronized CS low.
- Simultaneous SCLK fall and CS rise in the same cycle: CS wins. No shift occurs and the shift register is discarded.
- CS held low with no SCLK: MISO holds frame[31] indefinitely.
- SCLK toggling while CS is high: ignored; bit_count stays 0.
- Reset asserted mid-transaction: immediately IDLE. A CS still low after reset release does not start a frame until a fresh CS falling edge is seen.

Test Plan:
- Load temp_termoc=14'h0190, temp_internal=12'h190, status=0; master reads 32 bits at clk/10 → received 32'h0640_1900, frame_done pulses once, bit_count=32.
- status_in=3'b001 (OC), temp_termoc=14'h3FFC → frame = 32'hFFF1_0001 (fault bit 16 set, bits 17/3 zero).
- Master reads 14 bits then raises CS → received equals temp_termoc, frame_abort pulses, frame_done stays 0, next full read returns the same frame.
- Apply load with new values during SHIFT → current frame unchanged; the following transaction returns the new values.
- Master clocks 40 edges → bits 33..40 equal IDLE_MISO, bit_count saturates at 32, frame_done on CS rise.
- Pull rst low after 10 bits with CS still low → outputs at reset values; SCLK edges are ignored until CS goes high then low again, after which the frame restarts at bit 31.

Source files
------------

// File: rtl/tc1_emulator_if.sv
// SPI link between a Pmod TC1 master and the MAX31855-style responder.
// The master drives SCLK/CS and samples MISO on SCLK rising edges.
interface tc1_emulator_if;
  logic SCLK;
  logic CS;
  logic MISO;

  modport master (output SCLK, output CS, input MISO);
  modport slave  (input SCLK, input CS, output MISO);
endinterface

// File: rtl/tc1_emulator.sv
// MAX31855-style SPI responder: shifts a 32-bit thermocouple frame out on MISO while CS is low.
// SCLK/CS are oversampled and edge-detected in the clk domain.
module tc1_emulator #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic        IDLE_MISO   = 1'b0
) (
  input  logic                clk,
  input  logic                rst,
  tc1_emulator_if.slave       spi,
  input  logic [13:0]         temp_termoc_in,
  input  logic [11:0]         temp_internal_in,
  input  logic [2:0]          status_in,
  input  logic                load,
  output logic                busy,
  output logic                frame_done,
  output logic                frame_abort,
  output logic [5:0]          bit_count
);

  typedef enum logic [1:0] {StIdle, StShift, StTail} state_e;

  state_e state_q, state_d;
  logic [31:0] shift_q, shift_d;
  logic [31:0] shadow_q, pend_frame_q, frame_in;
  logic        pend_q;
  logic        miso_q, miso_d;
  logic [5:0]  count_q, count_d;
  logic        done_q, done_d, abort_q, abort_d;

  logic [SYNC_STAGES-1:0] sclk_sync_q, cs_sync_q, warm_q;
  logic sclk_prev_q, cs_prev_q, armed_q;
  logic sclk_s, cs_s, sclk_fall, cs_fall, cs_rise;

  assign frame_in = {temp_termoc_in, 1'b0, |status_in, temp_internal_in, 1'b0, status_in};

  // warm_q marks when the sync chain holds real samples rather than reset presets; a frame
  // may only start once CS has been seen high, so a CS held low across reset is ignored.
  always_ff @(posedge clk) begin
    if (!rst) begin
      sclk_sync_q <= '0;
      cs_sync_q   <= '1;
      warm_q      <= '0;
      sclk_prev_q <= 1'b0;
      cs_prev_q   <= 1'b1;
      armed_q     <= 1'b0;
    end else begin
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], spi.SCLK};
      cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], spi.CS};
      warm_q      <= {warm_q[SYNC_STAGES-2:0], 1'b1};
      sclk_prev_q <= sclk_s;
      cs_prev_q   <= cs_s;
      if (warm_q[SYNC_STAGES-1] && cs_s) armed_q <= 1'b1;
    end
  end

  assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
  assign cs_s      = cs_sync_q[SYNC_STAGES-1];
  assign sclk_fall = sclk_prev_q & ~sclk_s;
  assign cs_fall   = armed_q & cs_prev_q & ~cs_s;
  assign cs_rise   = ~cs_prev_q & cs_s;

  // Shadow frame; loads arriving mid-transaction are parked until the FSM is back in idle.
  always_ff @(posedge clk) begin
    if (!rst) begin
      shadow_q     <= '0;
      pend_frame_q <= '0;
      pend_q       <= 1'b0;
    end else if (load) begin
      if (state_q == StIdle) begin
        shadow_q <= frame_in;
        pend_q   <= 1'b0;
      end else begin
        pend_frame_q <= frame_in;
        pend_q       <= 1'b1;
      end
    end else if (pend_q && state_q == StIdle) begin
      shadow_q <= pend_frame_q;
      pend_q   <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= StIdle;
      shift_q <= '0;
      miso_q  <= IDLE_MISO;
      count_q <= '0;
      done_q  <= 1'b0;
      abort_q <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      miso_q  <= miso_d;
      count_q <= count_d;
      done_q  <= done_d;
      abort_q <= abort_d;
    end
  end

  // CS rise is checked before SCLK fall so a coincident fall never shifts.
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    miso_d  = miso_q;
    count_d = count_q;
    done_d  = 1'b0;
    abort_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        count_d = '0;
        miso_d  = IDLE_MISO;
        if (cs_fall) begin
          state_d = StShift;
          shift_d = shadow_q;
          miso_d  = shadow_q[31];
        end
      end
      StShift: begin
        if (cs_rise) begin
          state_d = StIdle;
          miso_d  = IDLE_MISO;
          abort_d = 1'b1;
        end else if (sclk_fall) begin
          count_d = count_q + 6'd1;
          shift_d = {shift_q[30:0], IDLE_MISO};
          if (count_q == 6'd31) begin
            state_d = StTail;
            miso_d  = IDLE_MISO;
          end else begin
            miso_d  = shift_q[30];
          end
        end
      end
      StTail: begin
        if (cs_rise) begin
          state_d = StIdle;
          miso_d  = IDLE_MISO;
          done_d  = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign spi.MISO    = miso_q;
  assign busy        = (state_q != StIdle);
  assign frame_done  = done_q;
  assign frame_abort = abort_q;
  assign bit_count   = count_q;

endmodule

// File: tb/tb_tc1_emulator.sv
// Scoreboard bench for tc1_emulator: a bit-banged SPI master reads frames while a monitor
// checks each frame_done/frame_abort pulse against queued expectations.
module tb_tc1_emulator;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [13:0] tt  = '0;
  logic [11:0] ti  = '0;
  logic [2:0]  st  = '0;
  logic        load = 1'b0;
  logic        busy, fd, fa;
  logic [5:0]  bc;

  always #5 clk = ~clk;

  tc1_emulator_if spi();

  tc1_emulator #(.SYNC_STAGES(2), .IDLE_MISO(1'b0)) dut (
    .clk              (clk),
    .rst              (rst),
    .spi              (spi),
    .temp_termoc_in   (tt),
    .temp_internal_in (ti),
    .status_in        (st),
    .load             (load),
    .busy             (busy),
    .frame_done       (fd),
    .frame_abort      (fa),
    .bit_count        (bc)
  );

  typedef struct {
    logic        done;
    logic        chk_data;
    logic [63:0] data;
    logic [5:0]  cnt;
    string       name;
  } exp_t;

  exp_t        sb[$];
  exp_t        e;
  logic [63:0] rx = '0;
  int          checks = 0;
  int          failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push(input logic done, input logic chk, input logic [63:0] data,
                      input logic [5:0] cnt, input string name);
    exp_t x;
    x.done = done; x.chk_data = chk; x.data = data; x.cnt = cnt; x.name = name;
    sb.push_back(x);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [13:0] t, input logic [11:0] i, input logic [2:0] s);
    tt = t; ti = i; st = s; load = 1'b1;
    tick(1);
    load = 1'b0;
  endtask

  // SCLK at clk/10: rise samples MISO, fall makes the DUT advance.
  task automatic clock_bits(input int n);
    for (int k = 0; k < n; k++) begin
      spi.SCLK = 1'b1;
      rx = {rx[62:0], spi.MISO};
      tick(5);
      spi.SCLK = 1'b0;
      tick(5);
    end
  endtask

  task automatic spi_read(input int n);
    rx = '0;
    spi.CS = 1'b0;
    tick(5);
    clock_bits(n);
    spi.CS = 1'b1;
    tick(10);
  endtask

  // Monitor: every end-of-frame pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (fd || fa) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_pulse: got done=%0b abort=%0b expected none", fd, fa);
      end else begin
        e = sb.pop_front();
        check({e.name, "_kind"}, {62'd0, fd, fa}, e.done ? 64'd2 : 64'd1);
        check({e.name, "_bitcount"}, {58'd0, bc}, {58'd0, e.cnt});
        if (e.chk_data) check({e.name, "_data"}, rx, e.data);
      end
    end
  end

  initial begin
    spi.CS = 1'b1;
    spi.SCLK = 1'b0;
    tick(3);
    check("rst_miso", {63'd0, spi.MISO}, 64'd0);
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_bitcount", {58'd0, bc}, 64'd0);
    check("rst_done", {63'd0, fd}, 64'd0);
    check("rst_abort", {63'd0, fa}, 64'd0);
    rst = 1'b1;
    tick(6);

    // SCLK activity with CS high is ignored.
    clock_bits(4);
    check("idle_sclk_bitcount", {58'd0, bc}, 64'd0);
    check("idle_sclk_busy", {63'd0, busy}, 64'd0);

    // Plain full read.
    do_load(14'h0190, 12'h190, 3'b000);
    push(1'b1, 1'b1, 64'h0640_1900, 6'd32, "full_a");
    spi_read(32);

    // CS low without SCLK holds the MSB; then a zero-bit abort.
    do_load(14'h3FFC, 12'h000, 3'b001);
    push(1'b0, 1'b0, 64'd0, 6'd0, "hold_abort");
    spi.CS = 1'b0;
    tick(20);
    check("hold_msb", {63'd0, spi.MISO}, 64'd1);
    check("hold_busy", {63'd0, busy}, 64'd1);
    check("hold_bitcount", {58'd0, bc}, 64'd0);
    spi.CS = 1'b1;
    tick(10);
    push(1'b1, 1'b1, 64'hFFF1_0001, 6'd32, "full_oc");
    spi_read(32);

    // Short 14-bit read, then the same frame again in full.
    push(1'b0, 1'b1, 64'h3FFC, 6'd14, "short14");
    spi_read(14);
    push(1'b1, 1'b1, 64'hFFF1_0001, 6'd32, "after_short");
    spi_read(32);

    // Loads during SHIFT: current frame unaffected, last load wins for the next one.
    do_load(14'h0190, 12'h190, 3'b000);
    push(1'b1, 1'b1, 64'h0640_1900, 6'd32, "during_load");
    fork
      spi_read(32);
      begin
        tick(60);
        do_load(14'h0555, 12'h0AA, 3'b010);
        tick(20);
        do_load(14'h1234, 12'hABC, 3'b100);
      end
    join
    push(1'b1, 1'b1, 64'h48D1_ABC4, 6'd32, "new_frame");
    spi_read(32);

    // 40 clocks: bits past 32 read IDLE_MISO and the count saturates.
    push(1'b1, 1'b1, 64'h48_D1AB_C400, 6'd32, "over40");
    spi_read(40);

    // Reset mid-transaction with CS held low.
    rx = '0;
    spi.CS = 1'b0;
    tick(5);
    clock_bits(10);
    rst = 1'b0;
    tick(2);
    check("midrst_miso", {63'd0, spi.MISO}, 64'd0);
    check("midrst_busy", {63'd0, busy}, 64'd0);
    check("midrst_bitcount", {58'd0, bc}, 64'd0);
    rst = 1'b1;
    tick(5);
    clock_bits(6);
    check("postrst_bitcount", {58'd0, bc}, 64'd0);
    check("postrst_busy", {63'd0, busy}, 64'd0);
    check("postrst_miso", {63'd0, spi.MISO}, 64'd0);
    spi.CS = 1'b1;
    tick(10);
    do_load(14'h2ABC, 12'h5A3, 3'b110);
    push(1'b1, 1'b1, 64'hAAF1_5A36, 6'd32, "restart");
    spi_read(32);

    tick(20);
    check("sb_empty", sb.size(), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
